// File: rtl/load_store_unit.sv
// load_store_unit
// Bridges the pipeline MEM stage to a byte-wide data memory. One load or
// store request is accepted at a time and broken into 1, 2 or 4 single-byte
// memory accesses. Loads are assembled little-endian and sign/zero extended.
// Misaligned or illegal requests are answered with Fault and touch no memory.
//
// Every output is a flop. The memory-port flops are loaded from the next-state
// decode, so they line up with the state. Resp_Valid, Fault and Data_Out are
// loaded while the FSM sits in RESP, so they appear one cycle after it.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   Req_Valid / Req_Ready  request handshake (ready only while idle)
//   Mem_Read, Mem_Write    request kind (exactly one must be set)
//   Funct_3                width/sign code (B, H, W, BU, HU)
//   Addr, Data_In          byte address and store data
//   Resp_Valid             one-cycle completion pulse
//   Data_Out, Fault        load result (0 for stores and faults) and fault flag
//   Bmem_*                 byte memory port (read data returns one cycle later)
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic [2:0]        Funct_3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Data_In,
    output logic              Resp_Valid,
    output logic [31:0]       Data_Out,
    output logic              Fault,
    output logic [ADDR_W-1:0] Bmem_Addr,
    output logic              Bmem_Re,
    output logic              Bmem_We,
    output logic [7:0]        Bmem_Wdata,
    input  logic [7:0]        Bmem_Rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Legality check of a request: kind, width code and alignment.
    function automatic logic req_fault(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lsb);
        logic bad;
        bad = (rd == wr);
        case (f3)
            3'b000:  bad = bad;
            3'b001:  bad = bad | lsb[0];
            3'b010:  bad = bad | (lsb != 2'b00);
            3'b100:  bad = bad | wr;
            3'b101:  bad = bad | wr | lsb[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Index of the final byte for a width code (N-1).
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        logic [1:0] li;
        case (f3[1:0])
            2'b00:   li = 2'd0;
            2'b01:   li = 2'd1;
            default: li = 2'd3;
        endcase
        return li;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          idx_r, idx_s;
    logic                is_load_r, fault_r;
    logic [2:0]          f3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r, asm_r;
    logic                accept_s, req_fault_s;
    logic [ADDR_W-1:0]   base_s, bm_addr_s;
    logic [31:0]         sdata_s, ext_s, resp_data_s;
    logic                load_s, bm_re_s, bm_we_s, cap_en_s;
    logic [7:0]          bm_wdata_s;
    logic [1:0]          cap_slot_s;

    // Next-state and byte-index sequencing.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        accept_s    = 1'b0;
        req_fault_s = req_fault(Mem_Read, Mem_Write, Funct_3, Addr[1:0]);
        case (state_r)
            IDLE: begin
                if (Req_Valid) begin
                    accept_s = 1'b1;
                    idx_s    = 2'd0;
                    if (req_fault_s) begin
                        state_s = RESP;
                    end else begin
                        state_s = ACCESS;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (idx_r == last_idx(f3_r)) begin
                    idx_s = 2'd0;
                    // Loads need one extra cycle to collect the final read byte.
                    if (is_load_r) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    idx_s = idx_r + 2'd1;
                end
            end
            DRAIN:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Memory-port values for the coming cycle; on accept the raw inputs are
    // used because the request latch is not loaded yet.
    always_comb begin
        base_s  = (state_r == IDLE) ? Addr      : addr_r;
        sdata_s = (state_r == IDLE) ? Data_In   : wdata_r;
        load_s  = (state_r == IDLE) ? Mem_Read  : is_load_r;
        if (state_s == ACCESS) begin
            bm_re_s    = load_s;
            bm_we_s    = ~load_s;
            bm_addr_s  = base_s + ADDR_W'(idx_s);
            bm_wdata_s = sdata_s[{idx_s, 3'b000} +: 8];
        end else begin
            bm_re_s    = 1'b0;
            bm_we_s    = 1'b0;
            bm_addr_s  = Bmem_Addr;
            bm_wdata_s = Bmem_Wdata;
        end
    end

    // Read data arrives one cycle after the read, so it lands in slot idx-1.
    always_comb begin
        cap_en_s   = 1'b0;
        cap_slot_s = idx_r - 2'd1;
        if ((state_r == ACCESS) && is_load_r && (idx_r != 2'd0)) begin
            cap_en_s = 1'b1;
        end else if (state_r == DRAIN) begin
            cap_en_s   = 1'b1;
            cap_slot_s = last_idx(f3_r);
        end else begin
            cap_en_s = 1'b0;
        end
    end

    // Width extension of the assembled load value.
    always_comb begin
        case (f3_r)
            3'b000:  ext_s = {{24{asm_r[7]}}, asm_r[7:0]};
            3'b001:  ext_s = {{16{asm_r[15]}}, asm_r[15:0]};
            3'b100:  ext_s = {24'd0, asm_r[7:0]};
            3'b101:  ext_s = {16'd0, asm_r[15:0]};
            default: ext_s = asm_r;
        endcase
        resp_data_s = (fault_r || !is_load_r) ? 32'd0 : ext_s;
    end

    // FSM state, byte index, request latch and load assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= 2'd0;
            is_load_r <= 1'b0;
            fault_r   <= 1'b0;
            f3_r      <= 3'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 32'd0;
            asm_r     <= 32'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (accept_s) begin
                is_load_r <= Mem_Read;
                fault_r   <= req_fault_s;
                f3_r      <= Funct_3;
                addr_r    <= Addr;
                wdata_r   <= Data_In;
                asm_r     <= 32'd0;
            end
            if (cap_en_s) begin
                asm_r[{cap_slot_s, 3'b000} +: 8] <= Bmem_Rdata;
            end
        end
    end

    // Registered byte-memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Bmem_Re    <= 1'b0;
            Bmem_We    <= 1'b0;
            Bmem_Addr  <= {ADDR_W{1'b0}};
            Bmem_Wdata <= 8'd0;
        end else begin
            Bmem_Re    <= bm_re_s;
            Bmem_We    <= bm_we_s;
            Bmem_Addr  <= bm_addr_s;
            Bmem_Wdata <= bm_wdata_s;
        end
    end

    // Registered handshake and response outputs; Data_Out holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Req_Ready  <= 1'b1;
            Resp_Valid <= 1'b0;
            Fault      <= 1'b0;
            Data_Out   <= 32'd0;
        end else begin
            Req_Ready  <= (state_s == IDLE);
            Resp_Valid <= (state_r == RESP);
            Fault      <= (state_r == RESP) && fault_r;
            if (state_r == RESP) begin
                Data_Out <= resp_data_s;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct_3;
    logic [7:0]  addr;
    logic [31:0] data_in, data_out;
    logic        resp_valid, fault;
    logic [7:0]  bmem_addr, bmem_wdata, bmem_rdata;
    logic        bmem_re, bmem_we;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req_Valid(req_valid), .Req_Ready(req_ready),
        .Mem_Read(mem_read), .Mem_Write(mem_write), .Funct_3(funct_3),
        .Addr(addr), .Data_In(data_in),
        .Resp_Valid(resp_valid), .Data_Out(data_out), .Fault(fault),
        .Bmem_Addr(bmem_addr), .Bmem_Re(bmem_re), .Bmem_We(bmem_we),
        .Bmem_Wdata(bmem_wdata), .Bmem_Rdata(bmem_rdata)
    );

    // Byte memory: synchronous read, data valid the cycle after Bmem_Re.
    logic [7:0] mem [256];
    logic       fill_en;
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else begin
            if (bmem_we) mem[bmem_addr] <= bmem_wdata;
            if (bmem_re) bmem_rdata <= mem[bmem_addr];
        end
    end

    // Monitors: write log with cycle stamps, strobe counts, response log.
    typedef struct { int c; logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic f; logic [31:0] d; } rsp_t;
    wr_t  wlog[$];
    rsp_t rlog[$];
    int   cyc = 0, re_cnt = 0, we_cnt = 0, resp_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bmem_we) wlog.push_back('{cyc, bmem_addr, bmem_wdata});
        if (bmem_re) re_cnt <= re_cnt + 1;
        if (bmem_we) we_cnt <= we_cnt + 1;
    end
    always @(negedge clk) begin
        if (resp_valid) begin
            rlog.push_back('{fault, data_out});
            resp_cnt <= resp_cnt + 1;
        end
    end

    int n_vec = 0, n_err = 0;
    logic [7:0] ref_mem [256];
    logic [2:0] okf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference model: legality, result, latency; applies stores to ref_mem.
    task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [7:0] a, input logic [31:0] d,
                         output bit flt, output logic [31:0] q, output int lat);
        int n;
        longint v;
        n   = nbytes(f3);
        flt = (rd == wr);
        if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) flt = 1;
        if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) flt = 1;
        if (n == 2 && (a % 2) != 0) flt = 1;
        if (n == 4 && (a % 4) != 0) flt = 1;
        q = 32'd0;
        if (flt) begin
            lat = 1;
        end else if (wr) begin
            lat = n + 1;
            for (int k = 0; k < n; k++) ref_mem[8'(a + k)] = d[8*k +: 8];
        end else begin
            lat = n + 2;
            v = 0;
            for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[8'(a + k)]) << (8 * k));
            if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            q = 32'(v);
        end
    endtask

    task automatic wait_ready(input string tag);
        int b;
        b = 0;
        @(negedge clk);
        while (!req_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [7:0] a, input logic [31:0] d, input string tag);
        bit flt;
        logic [31:0] q;
        int lat, got, n, wb, reb, web;
        wait_ready(tag);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct_3 = f3; addr = a; data_in = d;
        wb = wlog.size(); reb = re_cnt; web = we_cnt;
        n = nbytes(f3);
        model(rd, wr, f3, a, d, flt, q, lat);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk({tag, "/busy"}, 32'(req_ready), 32'd0);
        got = 0;
        while (!resp_valid && got < 20) begin
            @(posedge clk);
            #1;
            got++;
        end
        chk({tag, "/latency"}, 32'(got), 32'(lat));
        chk({tag, "/data"}, data_out, q);
        chk({tag, "/fault"}, 32'(fault), 32'(flt));
        chk({tag, "/idle"}, 32'(req_ready), 32'd1);
        if (flt) begin
            chk({tag, "/no_strobes"}, 32'((re_cnt - reb) + (we_cnt - web)), 32'd0);
        end else if (wr) begin
            chk({tag, "/nwrites"}, 32'(wlog.size() - wb), 32'(n));
            for (int k = 0; k < n && wb + k < wlog.size(); k++) begin
                chk({tag, "/waddr"}, 32'(wlog[wb+k].a), 32'(8'(a + k)));
                chk({tag, "/wdata"}, 32'(wlog[wb+k].d), 32'(d[8*k +: 8]));
                chk({tag, "/wcycle"}, 32'(wlog[wb+k].c - wlog[wb].c), 32'(k));
            end
        end else begin
            chk({tag, "/nreads"}, 32'(re_cnt - reb), 32'(n));
        end
        @(posedge clk);
        #1;
        chk({tag, "/pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, "/hold"}, data_out, q);
    endtask

    initial begin
        int wb, r0, rb, b;
        bit rd, wr;
        logic [2:0] f3;
        logic [7:0] a;
        bit   qflt [3];
        logic [31:0] qdat [3];
        int   qlat;
        bit   qrd [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] qf [3] = '{3'b010, 3'b010, 3'b100};
        logic [7:0] qa [3] = '{8'h30, 8'h30, 8'h31};

        rst_n = 1'b0; fill_en = 1'b1; req_valid = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; funct_3 = 3'd0; addr = 8'd0; data_in = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge clk);
        #1;
        chk("rst/ready", 32'(req_ready), 32'd1);
        chk("rst/resp", 32'(resp_valid), 32'd0);
        chk("rst/fault", 32'(fault), 32'd0);
        chk("rst/data", data_out, 32'd0);
        chk("rst/strobes", 32'({bmem_re, bmem_we}), 32'd0);
        chk("rst/baddr", 32'(bmem_addr), 32'd0);
        chk("rst/bwdata", 32'(bmem_wdata), 32'd0);
        @(negedge clk);
        fill_en = 1'b0; rst_n = 1'b1;

        // Directed cases.
        do_req(0, 1, 3'b010, 8'h10, 32'hDEADBEEF, "sw10");
        do_req(1, 0, 3'b010, 8'h10, 32'd0, "lw10");
        chk("lw10/lit", data_out, 32'hDEADBEEF);
        do_req(0, 1, 3'b000, 8'h20, 32'h00000080, "sb20");
        do_req(1, 0, 3'b000, 8'h20, 32'd0, "lb20");
        chk("lb20/lit", data_out, 32'hFFFFFF80);
        do_req(1, 0, 3'b100, 8'h20, 32'd0, "lbu20");
        chk("lbu20/lit", data_out, 32'h00000080);
        do_req(0, 1, 3'b001, 8'h22, 32'h00008001, "sh22");
        do_req(1, 0, 3'b001, 8'h22, 32'd0, "lh22");
        chk("lh22/lit", data_out, 32'hFFFF8001);
        do_req(1, 0, 3'b101, 8'h22, 32'd0, "lhu22");
        chk("lhu22/lit", data_out, 32'h00008001);
        do_req(1, 0, 3'b010, 8'h06, 32'd0, "lw06_mis");
        do_req(1, 0, 3'b001, 8'h03, 32'd0, "lh03_mis");
        do_req(1, 1, 3'b010, 8'h08, 32'h12345678, "rdwr_both");
        do_req(0, 1, 3'b100, 8'h08, 32'h12345678, "sbu_illegal");
        do_req(0, 1, 3'b010, 8'hFC, 32'h11223344, "swFC");
        do_req(1, 0, 3'b010, 8'hFC, 32'd0, "lwFC");
        chk("lwFC/lit", data_out, 32'h11223344);

        // Reset after two of four store bytes have been written.
        wait_ready("rstmid");
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        funct_3 = 3'b010; addr = 8'h40; data_in = 32'hA1B2C3D4;
        wb = wlog.size(); r0 = resp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid/ready", 32'(req_ready), 32'd1);
        chk("rstmid/strobes", 32'({bmem_re, bmem_we, resp_valid}), 32'd0);
        chk("rstmid/baddr", 32'(bmem_addr), 32'd0);
        ref_mem[8'h40] = 8'hD4;
        ref_mem[8'h41] = 8'hC3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid/nwrites", 32'(wlog.size() - wb), 32'd2);
        chk("rstmid/noresp", 32'(resp_cnt - r0), 32'd0);
        do_req(1, 0, 3'b010, 8'h40, 32'd0, "rstmid_lw");
        do_req(1, 0, 3'b000, 8'h41, 32'd0, "rstmid_lb");

        // Three queued requests with Req_Valid held high.
        rb = rlog.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; mem_read = qrd[i]; mem_write = !qrd[i];
            funct_3 = qf[i]; addr = qa[i]; data_in = 32'h5A6B7C8D;
            b = 0;
            while (!req_ready && b < 50) begin
                @(negedge clk);
                b++;
            end
            model(qrd[i], !qrd[i], qf[i], qa[i], 32'h5A6B7C8D, qflt[i], qdat[i], qlat);
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        b = 0;
        while (rlog.size() - rb < 3 && b < 40) begin
            @(posedge clk);
            b++;
        end
        repeat (3) @(posedge clk);
        chk("queue/count", 32'(rlog.size() - rb), 32'd3);
        for (int i = 0; i < 3 && rb + i < rlog.size(); i++) begin
            chk($sformatf("queue%0d/data", i), rlog[rb+i].d, qdat[i]);
            chk($sformatf("queue%0d/fault", i), 32'(rlog[rb+i].f), 32'(qflt[i]));
        end
        chk("queue2/lit", qdat[2], 32'h0000007C);

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            b = $urandom_range(0, 9);
            if (b < 5) begin
                rd = 1; wr = 0;
            end else if (b < 9) begin
                rd = 0; wr = 1;
            end else begin
                rd = 1'($urandom_range(0, 1)); wr = rd;
            end
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = okf[$urandom_range(0, 4)];
            a = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ((f3[1:0] == 2'b00) ? 8'hFF : (f3[1:0] == 2'b01) ? 8'hFE : 8'hFC);
            do_req(rd, wr, f3, a, $urandom, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
